// File: rtl/shift_pkg.sv
// Shared types, widths and helpers for the multi-cycle shift unit.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP_W  = 3;

    typedef enum logic [1:0] {
        SLL  = 2'd0,
        SRL  = 2'd1,
        SRA  = 2'd2,
        RSVD = 2'd3
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    function automatic int nsteps(input int bpc);
        return (SHAMT_W + bpc - 1) / bpc;
    endfunction

    function automatic logic [XLEN-1:0] bitreverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One narrow right-shift stage: shifts by amt * 2^(BPC*pos), filling vacated MSBs.
module shift_stage
    import shift_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [XLEN-1:0]   i_in,
    input  logic [BPC-1:0]    i_amt,
    input  logic [STEP_W-1:0] i_pos,
    input  logic              i_fill,
    output logic [XLEN-1:0]   o_out
);

    logic [2*XLEN-1:0] w_ext;
    logic [15:0]       w_dist;

    // Extending with a full word of fill bits lets one logical shift cover SRA too.
    assign w_ext  = {{XLEN{i_fill}}, i_in};
    assign w_dist = 16'(i_amt) << (BPC * i_pos);
    assign o_out  = XLEN'(w_ext >> w_dist);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle RV32 SLL/SRL/SRA unit consuming BPC shift-amount bits per cycle.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BPC        = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_data,
    input  logic [4:0]      req_shamt,
    input  logic [4:0]      req_tag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_tag,
    output logic            busy
);

    localparam int NSTEPS = nsteps(BPC);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    shift_op_t           r_op;
    shift_op_t           w_op_in;
    logic [XLEN-1:0]     r_work;
    logic [SHAMT_W-1:0]  r_shamt_rem;
    logic [STEP_W-1:0]   r_step;
    logic                r_fill;
    logic [4:0]          r_tag;

    logic                w_accept;
    logic                w_last;
    logic [SHAMT_W-1:0]  w_rem_nxt;
    logic [XLEN-1:0]     w_stage_out;

    assign w_op_in   = shift_op_t'(req_op);
    assign req_ready = (r_state == IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;
    assign w_rem_nxt = r_shamt_rem >> BPC;
    assign w_last    = (r_step == STEP_W'(NSTEPS - 1)) ||
                       ((EARLY_EXIT != 0) && (w_rem_nxt == '0));

    shift_stage #(.BPC(BPC)) u_stage (
        .i_in   (r_work),
        .i_amt  (r_shamt_rem[BPC-1:0]),
        .i_pos  (r_step),
        .i_fill (r_fill),
        .o_out  (w_stage_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_tag     = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ((req_shamt == '0) || (w_op_in == RSVD)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = (r_op == SLL) ? bitreverse(r_work) : r_work;
                rsp_tag   = r_tag;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    // SLL is done as reverse / right-shift / reverse so one right-shift stage serves all ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= SLL;
            r_work      <= '0;
            r_shamt_rem <= '0;
            r_step      <= '0;
            r_fill      <= 1'b0;
            r_tag       <= '0;
        end else if (w_accept) begin
            r_op        <= w_op_in;
            r_work      <= (w_op_in == SLL) ? bitreverse(req_data) : req_data;
            r_shamt_rem <= req_shamt;
            r_step      <= '0;
            r_fill      <= (w_op_in == SRA) && req_data[XLEN-1];
            r_tag       <= req_tag;
        end else if (r_state == SHIFT) begin
            r_work      <= w_stage_out;
            r_shamt_rem <= w_rem_nxt;
            r_step      <= r_step + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer across BPC 1..5 and both EARLY_EXIT settings.
module tb_shift_sequencer;

    localparam int NDUT = 10;   // instance k: BPC = k/2+1, EARLY_EXIT = k%2

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            rsp_ready;
    logic [NDUT-1:0] req_valid;
    logic [NDUT-1:0] req_ready;
    logic [NDUT-1:0] rsp_valid;
    logic [NDUT-1:0] busy;
    logic [1:0]      req_op;
    logic [31:0]     req_data;
    logic [4:0]      req_shamt;
    logic [4:0]      req_tag;
    logic [31:0]     rsp_data [NDUT];
    logic [4:0]      rsp_tag  [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        shift_sequencer #(
            .XLEN       (32),
            .BPC        (g / 2 + 1),
            .EARLY_EXIT (g % 2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_op    (req_op),
            .req_data  (req_data),
            .req_shamt (req_shamt),
            .req_tag   (req_tag),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready),
            .rsp_data  (rsp_data[g]),
            .rsp_tag   (rsp_tag[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        case (op)
            2'd0:    return d << sh;
            2'd1:    return d >> sh;
            2'd2:    return 32'($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    // Edges from T0 (last edge before the request is driven) until rsp_valid is seen.
    function automatic int ref_lat(input int bpc, input int ee, input logic [4:0] sh);
        int msb;
        if (sh == 5'd0) return 1;
        if (ee == 0) return (5 + bpc - 1) / bpc + 1;
        msb = 0;
        for (int b = 0; b < 5; b++) if (sh[b]) msb = b;
        return msb / bpc + 2;
    endfunction

    task automatic drive_req(input int k, input logic [1:0] op, input logic [31:0] d,
                             input logic [4:0] sh, input logic [4:0] tag);
        @(negedge clk);
        req_op       = op;
        req_data     = d;
        req_shamt    = sh;
        req_tag      = tag;
        req_valid[k] = 1'b1;
    endtask

    task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [4:0] tag,
                          input logic [31:0] exp_data, input int exp_lat, input string name);
        int lat;
        drive_req(k, op, d, sh, tag);
        n_checks++;
        if (req_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready: got %b expected 1", name, req_ready[k]);
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (rsp_data[k] !== exp_data || rsp_tag[k] !== tag) begin
            n_fail++;
            $display("FAIL %s result: got data=%h tag=%0d expected data=%h tag=%0d",
                     name, rsp_data[k], rsp_tag[k], exp_data, tag);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy[k] !== 1'b0 || rsp_valid[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return to idle: got busy=%b rsp_valid=%b expected 0/0",
                     name, busy[k], rsp_valid[k]);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = 2'd0;
        req_data  = '0;
        req_shamt = '0;
        req_tag   = '0;
        #12;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (rsp_valid[k] !== 1'b0 || busy[k] !== 1'b0 || rsp_data[k] !== 32'd0 || rsp_tag[k] !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got valid=%b busy=%b data=%h tag=%0d expected all 0",
                         k, rsp_valid[k], busy[k], rsp_data[k], rsp_tag[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== {NDUT{1'b1}}) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected all 1", req_ready);
        end
    endtask

    task automatic test_full_shift();
        run_op(0, 2'd2, 32'h8000_0000, 5'd31, 5'd7, 32'hFFFF_FFFF, 6, "sra31_b1e0");
        run_op(0, 2'd1, 32'hF000_0000, 5'd4, 5'd2, 32'h0F00_0000, 6, "srl4_b1e0");
    endtask

    task automatic test_early_exit();
        run_op(1, 2'd1, 32'hF000_0000, 5'd4, 5'd3, 32'h0F00_0000, 4, "srl4_b1e1");
        run_op(1, 2'd0, 32'h0000_0001, 5'd0, 5'd4, 32'h0000_0001, 1, "sll0_b1e1");
        run_op(3, 2'd0, 32'h0000_0003, 5'd2, 5'd5, 32'h0000_000C, 2, "sll2_b2e1");
    endtask

    task automatic test_bpc2();
        run_op(2, 2'd0, 32'h0000_0003, 5'd30, 5'd6, 32'hC000_0000, 4, "sll30_b2e0");
        run_op(2, 2'd3, 32'hDEAD_BEEF, 5'd5, 5'd1, 32'hDEAD_BEEF, 1, "rsvd_b2e0");
        run_op(8, 2'd2, 32'h8765_4321, 5'd17, 5'd8, 32'hFFFF_C3B2, 2, "sra17_b5e0");
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1, 2'd2, 32'hF000_0000, 5'd4, 5'd9);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        lat = 1;
        while (rsp_valid[1] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != 4 || rsp_data[1] !== 32'hFF00_0000 || rsp_tag[1] !== 5'd9) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d data=%h tag=%0d expected 4 ff000000 9",
                     lat, rsp_data[1], rsp_tag[1]);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'hFF00_0000 || rsp_tag[1] !== 5'd9 ||
                req_ready[1] !== 1'b0 || busy[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h tag=%0d ready=%b busy=%b expected 1 ff000000 9 0 1",
                         c, rsp_valid[1], rsp_data[1], rsp_tag[1], req_ready[1], busy[1]);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready[1] !== 1'b1 || busy[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%b busy=%b valid=%b expected 1 0 0",
                     req_ready[1], busy[1], rsp_valid[1]);
        end
    endtask

    task automatic test_flush();
        logic seen;
        drive_req(0, 2'd1, 32'hFFFF_FFFF, 5'd31, 5'd3);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        n_checks++;
        if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_during_shift: got busy=%b ready=%b expected 1 0", busy[0], req_ready[0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_to_idle: got busy=%b valid=%b expected 0 0", busy[0], rsp_valid[0]);
        end
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got %b expected 1", req_ready[0]);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_rsp: got rsp_valid seen=%b expected 0", seen);
        end
        @(negedge clk);
        flush        = 1'b1;
        req_valid[0] = 1'b1;
        req_shamt    = 5'd31;
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready: got %b expected 0", req_ready[0]);
        end
        @(posedge clk); #1;
        flush        = 1'b0;
        req_valid[0] = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_no_accept: got busy=%b valid=%b expected 0 0", busy[0], rsp_valid[0]);
        end
    endtask

    task automatic test_reset_mid();
        drive_req(0, 2'd2, 32'h8000_0000, 5'd31, 5'd7);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_data[0] !== 32'd0 || rsp_tag[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b valid=%b data=%h tag=%0d expected all 0",
                     busy[0], rsp_valid[0], rsp_data[0], rsp_tag[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 2'd1, 32'h1234_5678, 5'd8, 5'd4, 32'h0012_3456, 6, "srl8_after_reset");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [4:0]  tag;
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 6; i++) begin
                op  = 2'($urandom_range(0, 2));
                d   = $urandom;
                sh  = 5'($urandom_range(0, 31));
                tag = 5'($urandom_range(0, 31));
                run_op(k, op, d, sh, tag, ref_shift(op, d, sh), ref_lat(k / 2 + 1, k % 2, sh),
                       $sformatf("rand_k%0d_i%0d", k, i));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_shift();
        test_early_exit();
        test_bpc2();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift unit for the Execute stage. It performs RV32 SLL/SRL/SRA by consuming BPC bits of the shift amount per cycle through one narrow shift stage, instead of a full 5-level combinational shifter. It trades latency for area and timing. It sits beside the ALU with valid/ready handshakes on both sides, so issue logic can stall on it.

Parameters:
XLEN, 32, operand width (only 32 supported)
BPC, 1, shift-amount bits consumed per cycle (1..5)
EARLY_EXIT, 1, 1 = finish as soon as the remaining shamt bits are zero

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous kill of any in-flight op
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  2  shift_op_t: SLL=0, SRL=1, SRA=2, 3 reserved
req_data  in  32  operand
req_shamt  in  5  shift amount
req_tag  in  5  destination tag (rd), returned unchanged
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  shifted result
rsp_tag  out  5  tag of the result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, internal regs 0.
- req_ready = (state==IDLE) && !flush. Combinational, no dependence on req_valid.
- States:
  - IDLE: on accept (req_valid && req_ready):
    - latch tag, op, shamt, and fill = (op==SRA) ? req_data[31] : 0.
    - latch work = (op==SLL) ? bitreverse(req_data) : req_data.
    - step=0.
    - If shamt==0 or op==3, go to DONE with data unshifted; otherwise go to SHIFT.
  - SHIFT: each cycle:
    - work <= (work >> (shamt_rem[BPC-1:0] << (BPC*step))), vacated MSBs filled with the latched fill.
    - shamt_rem >>= BPC; step++.
    - Chunks are consumed LSB-first.
    - Leave to DONE when the last chunk is consumed (step == ceil(5/BPC)-1), or when EARLY_EXIT=1 and the post-shift shamt_rem==0.
  - DONE: rsp_valid=1.
    - rsp_data = (op==SLL) ? bitreverse(work) : work; rsp_tag = latched tag.
    - rsp_data and rsp_tag stay stable while rsp_ready=0.
    - On rsp_valid && rsp_ready, go to IDLE.
    - No accept in the same cycle (req_ready=0 in DONE).
- Latency: if the accept occurs on edge T0, rsp_valid rises after edge T0+N+1, where N = number of SHIFT cycles.
  - shamt==0: N=0.
  - EARLY_EXIT=0: N = ceil(5/BPC).
  - EARLY_EXIT=1: N = index of the highest nonzero chunk + 1.
- Fill bit always comes from the original operand MSB, never from intermediate work.
- flush: highest priority, in any state. Next state is IDLE, rsp_valid=0 from the next cycle, the result is discarded, and no request is accepted while flush=1.
- Reset mid-operation: identical to power-on reset; no response is produced.
- Throughput: at most one op per N+2 cycles.

Decomposition:
- shift_pkg: shift_op_t enum (SLL, SRL, SRA, RSVD); seq_state_t enum (IDLE, SHIFT, DONE); XLEN=32; SHAMT_W=5; function nsteps(BPC) = ceil(SHAMT_W/BPC).
- Sub-module shift_stage (combinational):
  - inputs: in[31:0], amt (BPC bits), pos (step index), fill.
  - output: in logically right-shifted by amt·2^(BPC·pos), filled with fill.
  - Instantiated once.
- The FSM, operand reversal and registers live in shift_sequencer.

Test Plan:
- BPC=1, EARLY_EXIT=0: SRA 0x80000000 shamt=31 tag=7 → after 5 SHIFT cycles, rsp_valid rises at T0+6 with rsp_data=0xFFFFFFFF, rsp_tag=7.
- BPC=1, EARLY_EXIT=1: SRL 0xF0000000 shamt=4 → N=3, rsp_data=0x0F000000 at T0+4. SLL 0x00000001 shamt=0 → rsp_data=0x00000001 at T0+1.
- BPC=2: SLL 0x00000003 shamt=30 → rsp_data=0xC0000000; with EARLY_EXIT=0, N=3.
- Backpressure: complete SRA 0xF0000000 shamt=4 (→0xFF000000), then hold rsp_ready=0 for 3 cycles → rsp_data and rsp_tag stable, req_ready=0 and busy=1 throughout. Raise rsp_ready → IDLE next cycle, req_ready=1.
- Flush: pulse flush during the 2nd SHIFT cycle → rsp_valid never asserts, state=IDLE, req_ready=1 the cycle after flush drops. Flush with req_valid=1 in IDLE → no accept.
- Reset: drop rst_n asynchronously mid-SHIFT → outputs go to 0 immediately. After release, req_ready=1 and a fresh SRL 0x12345678 shamt=8 → 0x00123456.
- Random compare against a reference >>, >>>, << model for all BPC values in 1..5.
